aes_key_expander: RTL

- Computes the full AES key schedule for AES-128, AES-192 and AES-256 from a cipher key, producing one 32-bit word per cycle.
- Stores all round keys and serves one 128-bit round key per read, indexed by the round number from the AES control FSM.
- Supports reverse-order reads for decryption.
- Sits between the key input registers and the round datapath.

---
 rtl/aes_key_expander.sv | 127 ++++++++++++
 1 files changed

// File: rtl/aes_key_expander.sv
// rtl/aes_key_expander.sv - AES-128/192/256 key schedule, one word per cycle, with round-key read port
// Words are generated into a 60-entry store; S-box lookups go through an external combinational unit.
module aes_key_expander (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   mode,
  input  logic [255:0] key_in,
  output logic [31:0]  sbox_word_o,
  input  logic [31:0]  sbox_word_i,
  input  logic [3:0]   rd_round,
  input  logic         rd_decrypt,
  output logic [127:0] round_key,
  output logic         busy,
  output logic         key_ready
);

  typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;

  state_t      state, state_nxt;
  logic [1:0]  mode_q;
  logic [5:0]  idx;
  logic [2:0]  k;
  logic [7:0]  rcon;
  logic [31:0] w [60];

  logic [3:0]  nk, nk_in, nr;
  logic [2:0]  k_last;
  logic [5:0]  idx_last;
  logic        accept;
  logic [31:0] temp_prev, temp, word_new;
  logic [3:0]  r;
  logic [5:0]  base;

  // Schedule geometry for the latched mode and for the mode presented with start
  always_comb begin
    nk       = 4'd4;
    nr       = 4'd10;
    k_last   = 3'd3;
    idx_last = 6'd43;
    case (mode_q)
      2'b01:   begin nk = 4'd6; nr = 4'd12; k_last = 3'd5; idx_last = 6'd51; end
      2'b10:   begin nk = 4'd8; nr = 4'd14; k_last = 3'd7; idx_last = 6'd59; end
      default: begin nk = 4'd4; nr = 4'd10; k_last = 3'd3; idx_last = 6'd43; end
    endcase
    case (mode)
      2'b01:   nk_in = 4'd6;
      2'b10:   nk_in = 4'd8;
      default: nk_in = 4'd4;
    endcase
  end

  assign accept = start && (mode != 2'b11) && (state != EXPAND);

  always_comb begin
    sbox_word_o = 32'h0;
    temp_prev   = w[idx - 6'd1];
    temp        = temp_prev;
    if (state == EXPAND) begin
      if (k == 3'd0) begin
        sbox_word_o = {temp_prev[23:0], temp_prev[31:24]};
        temp        = sbox_word_i ^ {rcon, 24'h0};
      end else if (nk == 4'd8 && k == 3'd4) begin
        sbox_word_o = temp_prev;
        temp        = sbox_word_i;
      end
    end
    word_new = w[idx - {2'b00, nk}] ^ temp;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, READY: if (accept) state_nxt = EXPAND;
      EXPAND:      if (idx == idx_last) state_nxt = READY;
      default:     state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      mode_q <= 2'b00;
      idx    <= 6'd0;
      k      <= 3'd0;
      rcon   <= 8'h00;
    end else begin
      state <= state_nxt;
      if (accept) begin
        mode_q <= mode;
        idx    <= {2'b00, nk_in};
        k      <= 3'd0;
        rcon   <= 8'h01;
      end else if (state == EXPAND) begin
        idx <= idx + 6'd1;
        k   <= (k == k_last) ? 3'd0 : k + 3'd1;
        if (k == 3'd0)
          rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1B : 8'h00);
      end
    end
  end

  // Word store is deliberately not reset; stale words are hidden by the read gating
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (accept) begin
        for (int j = 0; j < 8; j++)
          if (j < int'(nk_in)) w[j] <= key_in[255-32*j -: 32];
      end else if (state == EXPAND) begin
        w[idx] <= word_new;
      end
    end
  end

  assign r    = rd_decrypt ? (nr - rd_round) : rd_round;
  assign base = {r, 2'b00};

  always_comb begin
    round_key = 128'h0;
    if (state == READY && rd_round <= nr)
      round_key = {w[base], w[base + 6'd1], w[base + 6'd2], w[base + 6'd3]};
  end

  assign busy      = (state == EXPAND);
  assign key_ready = (state == READY);

endmodule
